// File: rtl/tt10_chronospatial_pkg.sv
// Shared types and constants for the tt10 chronospatial top.
// Used by the uio pad-bus scheduler and its arbiter.
package tt10_chronospatial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        DRIVE,
        SAMPLE
    } uio_sched_state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam logic [7:0] UIO_OE_DRIVE = 8'hFF;
    localparam logic [7:0] UIO_OE_HIZ   = 8'h00;

endpackage

// File: rtl/tt10_rr_arb2.sv
// Combinational 2-way round-robin arbiter; the owner of last_q keeps the history.
module tt10_rr_arb2 (
    input  logic       ena,
    input  logic [1:0] req_valid,
    input  logic       last_q,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (ena) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // On contention the requester not served last wins.
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/tt10_uio_bus_sched.sv
// Sequencer/arbiter for the shared 8-bit uio pad bus: two requesters, write = drive
// pads, read = sample pads, with a one-cycle high-Z turnaround on direction change.
module tt10_uio_bus_sched
    import tt10_chronospatial_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic        busy
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    uio_sched_state_t state_q, state_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;
    logic             write_q, write_d;
    logic             last_q, last_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       uio_oe_q, uio_oe_d;
    logic [7:0]       uio_out_q, uio_out_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;

    logic [1:0] grant;
    logic       gid;
    logic [7:0] gnt_wdata;

    tt10_rr_arb2 u_arb (
        .ena       (ena),
        .req_valid (req_valid),
        .last_q    (last_q),
        .grant     (grant)
    );

    assign gid       = grant[1];
    assign gnt_wdata = gid ? req_wdata[15:8] : req_wdata[7:0];
    assign req_ready = (state_q == IDLE) ? grant : 2'b00;

    always_comb begin
        // NOTE: every _d starts at its _q so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        dir_d       = dir_q;
        id_d        = id_q;
        write_d     = write_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        uio_oe_d    = uio_oe_q;
        uio_out_d   = uio_out_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = gid;
                    last_d  = gid;
                    write_d = req_write[gid];
                    wdata_d = gnt_wdata;
                    cnt_d   = '0;
                    if (req_write[gid] != dir_q) begin
                        state_d  = TURN;
                        uio_oe_d = UIO_OE_HIZ;
                    end else if (req_write[gid] == DIR_WRITE) begin
                        state_d   = DRIVE;
                        uio_oe_d  = UIO_OE_DRIVE;
                        uio_out_d = gnt_wdata;
                    end else begin
                        state_d  = SAMPLE;
                        uio_oe_d = UIO_OE_HIZ;
                    end
                end
            end
            TURN: begin
                dir_d = write_q;
                cnt_d = '0;
                if (write_q == DIR_WRITE) begin
                    state_d   = DRIVE;
                    uio_oe_d  = UIO_OE_DRIVE;
                    uio_out_d = wdata_q;
                end else begin
                    state_d = SAMPLE;
                end
            end
            DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d           = IDLE;
                    rsp_valid_d[id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d           = IDLE;
                    rsp_rdata_d       = uio_in;
                    rsp_valid_d[id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset releases the pads immediately, mid-transaction included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= DIR_READ;
            id_q        <= 1'b0;
            write_q     <= 1'b0;
            last_q      <= 1'b1;
            wdata_q     <= 8'h00;
            cnt_q       <= '0;
            uio_oe_q    <= UIO_OE_HIZ;
            uio_out_q   <= 8'h00;
            rsp_rdata_q <= 8'h00;
            rsp_valid_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            dir_q       <= dir_d;
            id_q        <= id_d;
            write_q     <= write_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            uio_oe_q    <= uio_oe_d;
            uio_out_q   <= uio_out_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign uio_oe    = uio_oe_q;
    assign uio_out   = uio_out_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/tt10_uio_bus_sched.md
# tt10_uio_bus_sched

Sequencer and arbiter for the shared 8-bit bidirectional `uio` pad bus of the tt10 chronospatial top. It time-multiplexes the pads between two internal requesters. Each transaction is a write (drive pads) or a read (sample pads). The block owns `uio_oe`/`uio_out` and inserts a one-cycle high-Z turnaround on every direction change, so that internal drivers and external drivers never overlap.

## Interface
- `HOLD_CYCLES`, 2: cycles a write value is driven on the pads; ≥1.
- `SETTLE_CYCLES`, 1: cycles the pads are released before a read sample; ≥1.

- `clk`  in  1  single clock; every register is in this domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design-selected; while low, no new grants are issued.
- `req_valid`  in  2  per-requester request; held until `req_ready`.
- `req_write`  in  2  1 = write, 0 = read; held with `req_valid`.
- `req_wdata`  in  16  write data; requester i uses bits [8i+7:8i].
- `req_ready`  out  2  one-hot accept pulse, combinational, IDLE only.
- `rsp_valid`  out  2  one-hot, one-cycle completion pulse, registered.
- `rsp_rdata`  out  8  read data, valid with `rsp_valid`; otherwise holds its last value.
- `uio_in`  in  8  pad inputs.
- `uio_out`  out  8  pad outputs, registered.
- `uio_oe`  out  8  pad enables, registered, either 8'h00 or 8'hFF.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states:
  - **IDLE**
    - Grant when `ena` is high and any `req_valid` bit is set.
    - `req_ready[g]` is 1 in that cycle. The block latches `id=g`, the write flag, and the wdata.
    - Next state is TURN if the request direction differs from `dir_q`. Otherwise DRIVE (write) or SAMPLE (read).
  - **TURN**
    - `uio_oe` = 0 for exactly 1 cycle.
    - Update `dir_q`, then go to DRIVE or SAMPLE.
  - **DRIVE**
    - `uio_oe`=FF and `uio_out`=wdata for HOLD_CYCLES cycles, then IDLE.
    - `rsp_valid[id]` pulses in the first IDLE cycle.
  - **SAMPLE**
    - `uio_oe`=0 for SETTLE_CYCLES cycles.
    - `uio_in` is registered into `rsp_rdata` at the edge that ends the last SAMPLE cycle.
    - Then IDLE, with `rsp_valid[id]` pulsing in that cycle.
- Arbitration: 2-way round-robin.
  - `last_q` records the last granted id.
  - On contention, grant `~last_q`. A lone requester is always granted.
  - After reset, requester 0 wins the first contention.
- Direction persists in IDLE.
  - After a write, `uio_oe` stays FF and `uio_out` holds the last wdata.
  - After a read, `uio_oe` stays 0.
- A grant may occur in the same IDLE cycle that carries `rsp_valid` for the previous transaction, giving back-to-back service.
- `ena` low: no grant is issued. An in-flight transaction completes normally. Pad state is held.
- `req_valid` dropped before `req_ready`: no transaction is started. Dropping it after `req_ready` has no effect.
- Reset values: state IDLE, `dir_q`=read, `uio_oe`=00, `uio_out`=00, `rsp_rdata`=00, `rsp_valid`=00, `last_q`=1, counter 0.
- Reset mid-operation: pads are released immediately (asynchronously). No `rsp_valid` is issued for the aborted transaction.
- Counter width is $clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1).

## Timing
- Grant in cycle T (IDLE).
- Write, same direction: pads are driven T+1..T+HOLD_CYCLES; `rsp_valid` at T+HOLD_CYCLES+1.
- Read, same direction: pads are released T+1..T+SETTLE_CYCLES; sample at the end of T+SETTLE_CYCLES; `rsp_valid` and `rsp_rdata` at T+SETTLE_CYCLES+1.
- A direction change adds exactly 1 cycle (TURN) after T.
- `uio_oe` never goes from FF to driven-with-new-read, or from 00 to FF, without either a TURN cycle or a same-direction path.
- Minimum issue interval per bus, same direction: HOLD_CYCLES+1 or SETTLE_CYCLES+1 cycles.

## Structure
- Package `tt10_chronospatial_pkg` holds:
  - the `uio_sched_state_t` enum (IDLE, TURN, DRIVE, SAMPLE);
  - the `DIR_READ`/`DIR_WRITE` constants;
  - the `UIO_OE_DRIVE`=8'hFF and `UIO_OE_HIZ`=8'h00 constants.
- Sub-module `tt10_rr_arb2`: combinational 2-way round-robin grant from `req_valid`, `last_q` and an enable input. The scheduler owns `last_q`.

## Test plan
- Reset, then a read by requester 0 with `uio_in`=8'h5A:
  - `req_ready`=01 at T; `uio_oe`=00 throughout; `rsp_valid`=01 and `rsp_rdata`=5A at T+2.
- Write by requester 1 with wdata 8'hC3 after the read:
  - TURN at T+1 with `uio_oe`=00; `uio_oe`=FF and `uio_out`=C3 at T+2..T+3; `rsp_valid`=10 at T+4.
- Both requesters writing continuously:
  - grants alternate 0,1,0,1 with no TURN;
  - `uio_oe` stays FF;
  - one grant every 3 cycles, coinciding with `rsp_valid`.
- `ena` dropped during DRIVE:
  - the current write completes with `rsp_valid`;
  - no further `req_ready` while `ena`=0;
  - the next grant comes in the first IDLE cycle after `ena` returns to 1.
- `rst_n` asserted mid-DRIVE: `uio_oe`=00 and `uio_out`=00 before the next clock edge; no `rsp_valid`; the first post-reset contention goes to requester 0.
- `req_valid` pulsed for 1 cycle while `busy`=1, then dropped: no grant and no `rsp_valid` for that requester.
